// File: rtl/ama_pipe_adder.sv
// ama_pipe_adder: carry-pipelined approximate mirror adder with valid/ready streaming.
// The low APPR_BITS bits use a per-transaction approximate cell; the upper bits are exact.
// Define ERR_STAT_EN to build the on-line error-statistics unit (err_sum/err_cnt/err_max).
module ama_pipe_adder #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned APPR_BITS = 8,
    parameter int unsigned STAGES    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    input  logic             stat_clr,
    output logic [47:0]      err_sum,
    output logic [31:0]      err_cnt,
    output logic [WIDTH:0]   err_max
);
    localparam int unsigned SW = WIDTH / STAGES;
    localparam int unsigned EW = WIDTH + 2;

    logic en;

    // Whole pipe advances together unless a held result is waiting downstream.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Ripple one SW-bit slice; bits below APPR_BITS use the cell chosen by md.
    function automatic logic [SW:0] add_chunk(
        input logic [SW-1:0] x,
        input logic [SW-1:0] y,
        input logic          ci,
        input logic [2:0]    md,
        input int unsigned   base
    );
        logic [SW-1:0] sum;
        logic          c;
        logic          mj;
        sum = '0;
        c   = ci;
        for (int unsigned j = 0; j < SW; j++) begin
            mj = (x[j] & y[j]) | (x[j] & c) | (y[j] & c);
            if (base + j >= APPR_BITS) begin
                sum[j] = x[j] ^ y[j] ^ c;
                c      = mj;
            end else begin
                case (md)
                    3'd1: begin sum[j] = ~mj;          c = mj;   end
                    3'd2: begin sum[j] = ~mj;          c = x[j]; end
                    3'd3: begin sum[j] = ~x[j] & y[j]; c = x[j]; end
                    3'd4: begin sum[j] = y[j];         c = x[j]; end
                    default: begin
                        sum[j] = x[j] ^ y[j] ^ c;
                        c      = mj;
                    end
                endcase
            end
        end
        return {c, sum};
    endfunction

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam int unsigned LO = SW * g;

        logic             src_v;
        logic             src_c;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;
        logic [2:0]       src_m;
        logic [SW:0]      res;
        logic [WIDTH-1:0] nxt_s;
        logic             vld_q;
        logic             c_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;
        logic [2:0]       m_q;
        logic             unused_q;
`ifdef ERR_STAT_EN
        logic [WIDTH:0]   src_x;
        logic [WIDTH:0]   x_q;
`endif

        if (g == 0) begin : g_head
            assign src_v = in_valid;
            assign src_c = cin;
            assign src_a = a;
            assign src_b = b;
            assign src_s = '0;
            assign src_m = mode;
`ifdef ERR_STAT_EN
            assign src_x = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
`endif
        end else begin : g_body
            assign src_v = g_stage[g-1].vld_q;
            assign src_c = g_stage[g-1].c_q;
            assign src_a = g_stage[g-1].a_q;
            assign src_b = g_stage[g-1].b_q;
            assign src_s = g_stage[g-1].s_q;
            assign src_m = g_stage[g-1].m_q;
`ifdef ERR_STAT_EN
            assign src_x = g_stage[g-1].x_q;
`endif
        end

        // Slice g of the sum, merged into the partial sum carried down the pipe.
        assign res = add_chunk(src_a[LO +: SW], src_b[LO +: SW], src_c, src_m, LO);

        always_comb begin
            nxt_s           = src_s;
            nxt_s[LO +: SW] = res[SW-1:0];
        end

        // Operands already consumed by earlier slices are still carried whole.
        assign unused_q = ^{a_q, b_q, m_q};

        // Stage register: valid, operands, mode, partial sum and inter-stage carry.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                s_q   <= '0;
                m_q   <= '0;
`ifdef ERR_STAT_EN
                x_q   <= '0;
`endif
            end else if (en) begin
                vld_q <= src_v;
                c_q   <= res[SW];
                a_q   <= src_a;
                b_q   <= src_b;
                s_q   <= nxt_s;
                m_q   <= src_m;
`ifdef ERR_STAT_EN
                x_q   <= src_x;
`endif
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign s         = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;

`ifdef ERR_STAT_EN
    logic signed [EW-1:0] err_c;
    logic [WIDTH:0]       abs_c;

    assign err_c = $signed({1'b0, cout, s}) - $signed({1'b0, g_stage[STAGES-1].x_q});
    assign abs_c = err_c[EW-1] ? (WIDTH+1)'(-err_c) : (WIDTH+1)'(err_c);

    // Accumulate error statistics on each output handshake; clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sum <= '0;
            err_cnt <= '0;
            err_max <= '0;
        end else if (stat_clr) begin
            err_sum <= '0;
            err_cnt <= '0;
            err_max <= '0;
        end else if (out_valid && out_ready) begin
            err_sum <= err_sum + 48'(err_c);
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + 32'd1;
            end
            if (abs_c > err_max) begin
                err_max <= abs_c;
            end
        end
    end
`else
    logic unused_stat;

    assign unused_stat = stat_clr;
    assign err_sum     = '0;
    assign err_cnt     = '0;
    assign err_max     = '0;
`endif

endmodule

// File: tb/tb_ama_pipe_adder.sv
// tb_ama_pipe_adder: directed + random checks of ama_pipe_adder against an arithmetic reference.
module tb_ama_pipe_adder;
    localparam int unsigned WIDTH     = 32;
    localparam int unsigned APPR_BITS = 8;
    localparam int unsigned STAGES    = 4;
`ifdef ERR_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic [2:0]       mode = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             stat_clr = 1'b0;
    logic [47:0]      err_sum;
    logic [31:0]      err_cnt;
    logic [WIDTH:0]   err_max;

    typedef struct {
        logic [32:0] appr;
        logic [32:0] exact;
        int          t;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          n_edges = 0;
    int          n_in = 0;
    int          n_out = 0;
    bit          chk_lat = 1'b1;
    bit          clr_on_out = 1'b0;
    logic [32:0] last_out = '0;
    logic [47:0] m_sum = '0;
    logic [31:0] m_cnt = '0;
    logic [32:0] m_max = '0;

    ama_pipe_adder #(.WIDTH(WIDTH), .APPR_BITS(APPR_BITS), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout),
        .stat_clr(stat_clr), .err_sum(err_sum), .err_cnt(err_cnt), .err_max(err_max)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: approximate cells applied to the low bits, plain addition above them.
    function automatic logic [32:0] ref_sum(input logic [31:0] x, input logic [31:0] y,
                                            input logic c, input logic [2:0] m);
        int              n;
        logic [31:0]     lo;
        logic            cc;
        logic            mj;
        longint unsigned up;
        n  = (m >= 3'd1 && m <= 3'd4) ? int'(APPR_BITS) : 0;
        lo = '0;
        cc = c;
        for (int i = 0; i < n; i++) begin
            mj = (int'(x[i]) + int'(y[i]) + int'(cc)) >= 2;
            case (m)
                3'd1:    begin lo[i] = ~mj;          cc = mj;   end
                3'd2:    begin lo[i] = ~mj;          cc = x[i]; end
                3'd3:    begin lo[i] = ~x[i] & y[i]; cc = x[i]; end
                default: begin lo[i] = y[i];         cc = x[i]; end
            endcase
        end
        up = (64'(x) >> n) + (64'(y) >> n) + 64'(cc);
        return 33'((up << n) | 64'(lo));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rand();
        in_valid = 1'b1;
        a        = $urandom;
        b        = $urandom;
        cin      = 1'($urandom_range(0, 1));
        mode     = 3'($urandom_range(0, 7));
    endtask

    // One clock: observe handshakes at negedge, update scoreboard/stat model, check stats after edge.
    task automatic cycle();
        logic   hs_in;
        logic   hs_out;
        logic   clr_now;
        exp_t   e;
        longint err;
        longint ae;
        @(negedge clk);
        hs_in  = in_valid && in_ready;
        hs_out = out_valid && out_ready;
        if (clr_on_out && out_valid) stat_clr = 1'b1;
        clr_now = stat_clr;
        if (hs_out) begin
            chk("output_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sum", 64'({cout, s}), 64'(e.appr));
                if (chk_lat) chk("latency", 64'(n_edges - e.t), 64'(STAGES));
                last_out = {cout, s};
                n_out++;
                if (!clr_now) begin
                    err   = longint'(e.appr) - longint'(e.exact);
                    ae    = (err < 0) ? -err : err;
                    m_sum = m_sum + 48'(err);
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                    if (33'(ae) > m_max) m_max = 33'(ae);
                end
            end
        end
        if (clr_now) begin
            m_sum = '0;
            m_cnt = '0;
            m_max = '0;
        end
        if (hs_in) begin
            e.appr  = ref_sum(a, b, cin, mode);
            e.exact = 33'(64'(a) + 64'(b) + 64'(cin));
            e.t     = n_edges;
            sb.push_back(e);
            n_in++;
        end
        @(posedge clk);
        n_edges++;
        #1;
        if (clr_now) stat_clr = 1'b0;
        chk("err_sum", 64'(err_sum), 64'(STAT_EN ? m_sum : 48'd0));
        chk("err_cnt", 64'(err_cnt), 64'(STAT_EN ? m_cnt : 32'd0));
        chk("err_max", 64'(err_max), 64'(STAT_EN ? m_max : 33'd0));
    endtask

    initial begin
        logic [32:0] snap;
        int          base_out;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_s", 64'({cout, s}), 64'(0));
        chk("rst_err_sum", 64'(err_sum), 64'(0));
        chk("rst_err_cnt", 64'(err_cnt), 64'(0));
        chk("rst_err_max", 64'(err_max), 64'(0));
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Exact mode, full carry ripple into cout
        in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b0; mode = 3'd0;
        cycle();
        in_valid = 1'b0;
        repeat (6) cycle();
        chk("t1_result", 64'(last_out), 64'(33'h1_0000_0000));
        chk("t1_err_cnt", 64'(err_cnt), 64'(STAT_EN ? 32'd1 : 32'd0));
        chk("t1_err_sum", 64'(err_sum), 64'(0));

        // AMA5 on low bits: positive error of 16
        in_valid = 1'b1; a = 32'h0000_00F0; b = 32'h0000_000F; cin = 1'b0; mode = 3'd4;
        cycle();
        in_valid = 1'b0;
        repeat (6) cycle();
        chk("t2_result", 64'(last_out), 64'(33'h0_0000_010F));
        chk("t2_err_sum", 64'(err_sum), 64'(STAT_EN ? 48'd16 : 48'd0));
        chk("t2_err_max", 64'(err_max), 64'(STAT_EN ? 33'd16 : 33'd0));
        chk("t2_err_cnt", 64'(err_cnt), 64'(STAT_EN ? 32'd2 : 32'd0));

        // 16 back-to-back random transactions
        base_out = n_out;
        for (int i = 0; i < 16; i++) begin
            drive_rand();
            chk("t3_in_ready", 64'(in_ready), 64'(1));
            cycle();
        end
        in_valid = 1'b0;
        repeat (STAGES + 2) cycle();
        chk("t3_count", 64'(n_out - base_out), 64'(16));
        chk("t3_drained", 64'(sb.size()), 64'(0));

        // Backpressure with a full pipe
        chk_lat = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_rand();
            cycle();
        end
        drive_rand();
        out_ready = 1'b0;
        #1;
        chk("t4_out_valid", 64'(out_valid), 64'(1));
        snap = {cout, s};
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t4_in_ready", 64'(in_ready), 64'(0));
            chk("t4_hold", 64'({cout, s}), 64'(snap));
            chk("t4_hold_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            cycle();
        end
        in_valid = 1'b0;
        repeat (STAGES + 4) cycle();
        chk("t4_drained", 64'(sb.size()), 64'(0));
        chk("t4_in_eq_out", 64'(n_in), 64'(n_out));
        chk_lat = 1'b1;

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            cycle();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        n_edges++;
        #1;
        chk("t5_out_valid", 64'(out_valid), 64'(0));
        chk("t5_err_cnt", 64'(err_cnt), 64'(0));
        chk("t5_err_sum", 64'(err_sum), 64'(0));
        chk("t5_err_max", 64'(err_max), 64'(0));
        sb.delete();
        n_in  = n_out;
        m_sum = '0; m_cnt = '0; m_max = '0;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("t5_no_output", 64'(out_valid), 64'(0));
        end

        // Statistics clear coincident with an output handshake
        for (int i = 0; i < 2; i++) begin
            drive_rand();
            mode = 3'd1;
            cycle();
        end
        in_valid = 1'b0;
        repeat (STAGES + 2) cycle();
        drive_rand();
        cycle();
        in_valid   = 1'b0;
        clr_on_out = 1'b1;
        repeat (STAGES + 2) cycle();
        clr_on_out = 1'b0;
        chk("t6_clr_sum", 64'(err_sum), 64'(0));
        chk("t6_clr_cnt", 64'(err_cnt), 64'(0));
        chk("t6_clr_max", 64'(err_max), 64'(0));
        drive_rand();
        cycle();
        in_valid = 1'b0;
        repeat (STAGES + 2) cycle();
        chk("t6_cnt_after", 64'(err_cnt), 64'(STAT_EN ? 32'd1 : 32'd0));
        chk("t6_drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
